// File: rtl/id_ex_skid_reg.sv
// ID/EX boundary register built as a 2-entry skid buffer.
// Registered valid/ready on both sides, with flush and sync reset.
module id_ex_skid_reg #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 4,
    parameter int RD_WIDTH   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_rs_a,
    input  logic [DATA_WIDTH-1:0] in_rs_b,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic                  in_alu_src,
    input  logic [OP_WIDTH-1:0]   in_alu_op,
    input  logic [RD_WIDTH-1:0]   in_rd,
    input  logic                  in_reg_write,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_rs_a,
    output logic [DATA_WIDTH-1:0] out_rs_b,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic                  out_alu_src,
    output logic [OP_WIDTH-1:0]   out_alu_op,
    output logic [RD_WIDTH-1:0]   out_rd,
    output logic                  out_reg_write
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rs_a;
        logic [DATA_WIDTH-1:0] rs_b;
        logic [DATA_WIDTH-1:0] imm;
        logic                  alu_src;
        logic [OP_WIDTH-1:0]   alu_op;
        logic [RD_WIDTH-1:0]   rd;
        logic                  reg_write;
    } id_ex_t;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_TWO
    } state_t;

    state_t state;
    id_ex_t main_q;
    id_ex_t skid_q;
    id_ex_t in_pl;
    logic   in_ready_q;
    logic   out_valid_q;
    logic   in_xfer;
    logic   out_xfer;

    assign in_pl = '{
        rs_a:      in_rs_a,
        rs_b:      in_rs_b,
        imm:       in_imm,
        alu_src:   in_alu_src,
        alu_op:    in_alu_op,
        rd:        in_rd,
        reg_write: in_reg_write
    };

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    // Occupancy FSM; ready/valid are flops updated alongside state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
        end else if (flush) begin
            state       <= S_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                S_EMPTY: begin
                    if (in_xfer) begin
                        main_q      <= in_pl;
                        state       <= S_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                S_ONE: begin
                    unique case (1'b1)
                        (in_xfer & out_xfer): begin
                            main_q <= in_pl;
                        end
                        (in_xfer & ~out_xfer): begin
                            skid_q     <= in_pl;
                            state      <= S_TWO;
                            in_ready_q <= 1'b0;
                        end
                        (~in_xfer & out_xfer): begin
                            state       <= S_EMPTY;
                            out_valid_q <= 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end
                S_TWO: begin
                    if (out_xfer) begin
                        main_q     <= skid_q;
                        state      <= S_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_rs_a      = main_q.rs_a;
    assign out_rs_b      = main_q.rs_b;
    assign out_imm       = main_q.imm;
    assign out_alu_src   = main_q.alu_src;
    assign out_alu_op    = main_q.alu_op;
    assign out_rd        = main_q.rd;
    assign out_reg_write = main_q.reg_write & out_valid_q;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Bench for id_ex_skid_reg: queue-based reference model,
// directed scenarios with literal expectations, then random traffic.
module tb_id_ex_skid_reg;

    typedef struct packed {
        logic [7:0] rs_a;
        logic [7:0] rs_b;
        logic [7:0] imm;
        logic       alu_src;
        logic [3:0] alu_op;
        logic [2:0] rd;
        logic       reg_write;
    } ent_t;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_rs_a;
    logic [7:0] in_rs_b;
    logic [7:0] in_imm;
    logic       in_alu_src;
    logic [3:0] in_alu_op;
    logic [2:0] in_rd;
    logic       in_reg_write;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_rs_a;
    logic [7:0] out_rs_b;
    logic [7:0] out_imm;
    logic       out_alu_src;
    logic [3:0] out_alu_op;
    logic [2:0] out_rd;
    logic       out_reg_write;

    id_ex_skid_reg #(
        .DATA_WIDTH(8),
        .OP_WIDTH  (4),
        .RD_WIDTH  (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rs_a      (in_rs_a),
        .in_rs_b      (in_rs_b),
        .in_imm       (in_imm),
        .in_alu_src   (in_alu_src),
        .in_alu_op    (in_alu_op),
        .in_rd        (in_rd),
        .in_reg_write (in_reg_write),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rs_a     (out_rs_a),
        .out_rs_b     (out_rs_b),
        .out_imm      (out_imm),
        .out_alu_src  (out_alu_src),
        .out_alu_op   (out_alu_op),
        .out_rd       (out_rd),
        .out_reg_write(out_reg_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks;
    int   failures;
    ent_t q[$];
    bit   zero_out;
    bit   cmp_en;
    bit   last_acc;
    ent_t cur;
    int   seen_aa;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    task automatic drive(ent_t e);
        in_rs_a      = e.rs_a;
        in_rs_b      = e.rs_b;
        in_imm       = e.imm;
        in_alu_src   = e.alu_src;
        in_alu_op    = e.alu_op;
        in_rd        = e.rd;
        in_reg_write = e.reg_write;
    endtask

    function automatic ent_t mk(logic [7:0] a, logic [7:0] b,
                                logic [7:0] im, logic src,
                                logic [2:0] rd);
        ent_t e;
        e.rs_a      = a;
        e.rs_b      = b;
        e.imm       = im;
        e.alu_src   = src;
        e.alu_op    = 4'h3;
        e.rd        = rd;
        e.reg_write = 1'b1;
        return e;
    endfunction

    // Compare DUT outputs against the queue model.
    task automatic compare();
        if (cmp_en) begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
            chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
            if (out_valid && out_rs_a == 8'hAA) seen_aa++;
            if (q.size() > 0) begin
                chk("out_rs_a", {24'b0, out_rs_a}, {24'b0, q[0].rs_a});
                chk("out_rs_b", {24'b0, out_rs_b}, {24'b0, q[0].rs_b});
                chk("out_imm", {24'b0, out_imm}, {24'b0, q[0].imm});
                chk("out_alu_src", {31'b0, out_alu_src},
                    {31'b0, q[0].alu_src});
                chk("out_alu_op", {28'b0, out_alu_op},
                    {28'b0, q[0].alu_op});
                chk("out_rd", {29'b0, out_rd}, {29'b0, q[0].rd});
                chk("out_reg_write", {31'b0, out_reg_write},
                    {31'b0, q[0].reg_write});
            end else begin
                chk("idle_reg_write", {31'b0, out_reg_write}, 32'd0);
                if (zero_out) begin
                    chk("reset_payload",
                        {out_rs_a, out_rs_b, out_imm, out_alu_src,
                         out_alu_op, out_rd},
                        32'd0);
                end
            end
        end
    endtask

    // One clock: ready probe, compare at negedge, model update at posedge.
    task automatic tick();
        logic o;
        bit   in_x;
        bit   out_x;
        #1;
        if (cmp_en) begin
            o = out_ready;
            out_ready = ~o;
            #1;
            chk("ready_no_comb", {31'b0, in_ready}, {31'b0, q.size() < 2});
            out_ready = o;
        end
        @(negedge clk);
        compare();
        @(posedge clk);
        in_x  = in_valid && (q.size() < 2);
        out_x = out_ready && (q.size() > 0);
        last_acc = in_x;
        if (rst) begin
            q.delete();
            zero_out = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            if (out_x) void'(q.pop_front());
            if (in_x) begin
                q.push_back(cur);
                zero_out = 1'b0;
            end
        end
        #1;
    endtask

    task automatic send(ent_t e);
        cur = e;
        drive(e);
        in_valid = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        zero_out = 1'b1;
        cmp_en   = 1'b0;
        seen_aa  = 0;
        last_acc = 1'b0;
        flush    = 1'b0;
        out_ready = 1'b0;

        // Reset held two cycles with valid input present.
        rst = 1'b1;
        send(mk(8'h5A, 8'h5B, 8'h5C, 1'b1, 3'd7));
        tick();
        cmp_en = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_fields",
            {out_rs_a, out_rs_b, out_imm, out_alu_src, out_alu_op,
             out_rd},
            32'd0);
        chk("rst_reg_write", {31'b0, out_reg_write}, 32'd0);
        tick();

        // Streaming with out_ready high.
        out_ready = 1'b1;
        send(mk(8'h11, 8'h22, 8'h7F, 1'b1, 3'd1));
        tick();
        chk("s0_valid", {31'b0, out_valid}, 32'd1);
        chk("s0_rs_a", {24'b0, out_rs_a}, 32'h11);
        chk("s0_imm", {24'b0, out_imm}, 32'h7F);
        chk("s0_src", {31'b0, out_alu_src}, 32'd1);
        send(mk(8'h33, 8'h44, 8'h80, 1'b0, 3'd2));
        tick();
        chk("s1_rs_a", {24'b0, out_rs_a}, 32'h33);
        chk("s1_rs_b", {24'b0, out_rs_b}, 32'h44);
        chk("s1_imm", {24'b0, out_imm}, 32'h80);
        chk("s1_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b0;
        tick();
        chk("s_drain", {31'b0, out_valid}, 32'd0);

        // Backpressure: E1 out, E2 skid, E3 held off.
        out_ready = 1'b0;
        send(mk(8'h0E, 8'h01, 8'h00, 1'b0, 3'd1));
        tick();
        send(mk(8'h0E, 8'h02, 8'h00, 1'b0, 3'd2));
        tick();
        chk("bp_ready0", {31'b0, in_ready}, 32'd0);
        chk("bp_e1", {24'b0, out_rs_b}, 32'h01);
        send(mk(8'h0E, 8'h03, 8'h00, 1'b0, 3'd3));
        tick();
        tick();
        chk("bp_hold_e1", {24'b0, out_rs_b}, 32'h01);
        out_ready = 1'b1;
        tick();
        chk("bp_e2", {24'b0, out_rs_b}, 32'h02);
        tick();
        chk("bp_e3", {24'b0, out_rs_b}, 32'h03);
        in_valid = 1'b0;
        tick();
        chk("bp_drain", {31'b0, out_valid}, 32'd0);

        // Flush while both entries are held.
        out_ready = 1'b0;
        send(mk(8'h21, 8'h00, 8'h00, 1'b0, 3'd1));
        tick();
        send(mk(8'h22, 8'h00, 8'h00, 1'b0, 3'd2));
        tick();
        send(mk(8'hAA, 8'h00, 8'h00, 1'b0, 3'd4));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_reg_write", {31'b0, out_reg_write}, 32'd0);
        chk("fl_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("fl_no_residual", {31'b0, out_valid}, 32'd0);

        // Flush coincident with an output transfer.
        send(mk(8'h05, 8'h00, 8'h00, 1'b0, 3'd5));
        tick();
        in_valid = 1'b0;
        chk("fc_rd5", {29'b0, out_rd}, 32'd5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fc_empty", {31'b0, out_valid}, 32'd0);
        tick();

        // Random traffic; decode holds payload until accepted.
        in_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (!in_valid || last_acc) begin
                ent_t e;
                e.rs_a      = 8'($urandom);
                e.rs_b      = 8'($urandom);
                e.imm       = 8'($urandom);
                e.alu_src   = 1'($urandom);
                e.alu_op    = 4'($urandom);
                e.rd        = 3'($urandom);
                e.reg_write = 1'($urandom);
                if (e.rs_a == 8'hAA) e.rs_a = 8'hAB;
                send(e);
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = (i % 200 < 100) ? ($urandom_range(0, 3) != 0)
                                        : ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("never_aa", seen_aa, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
